// File: rtl/hazard_pkg.sv
// Shared widths and types for the multicycle hazard unit.
package hazard_pkg;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned LAT_W_DEF = 3;
    localparam logic [LAT_W_DEF-1:0] LAT_WAIT_WB = '1;

    typedef logic [LAT_W_DEF-1:0] lat_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/multicycle_hazard_unit_if.sv
// ID-stage / writeback / stall signals seen by the hazard unit.
interface multicycle_hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LAT_W    = LAT_W_DEF,
    parameter int unsigned CNT_W    = 32
);
    logic                         id_valid;
    logic [NUM_SRC*REG_IDX_W-1:0] id_rs;
    logic [NUM_SRC-1:0]           id_rs_used;
    reg_idx_t                     id_rd;
    logic                         id_rd_we;
    logic [LAT_W-1:0]             id_lat;
    logic                         flush;
    logic                         wb_valid;
    reg_idx_t                     wb_rd;
    logic                         stall_if_id;
    logic                         bubble_ex;
    logic [NUM_SRC-1:0]           src_hazard;
    logic [NUM_REGS-1:0]          busy_mask;
    logic [CNT_W-1:0]             stall_cycles;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_rd_we, id_lat,
               flush, wb_valid, wb_rd,
        input  stall_if_id, bubble_ex, src_hazard, busy_mask, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_rd_we, id_lat,
               flush, wb_valid, wb_rd,
        output stall_if_id, bubble_ex, src_hazard, busy_mask, stall_cycles
    );
endinterface

// File: rtl/hazard_reg_counter.sv
// One register's scoreboard entry: countdown or wait-for-writeback.
module hazard_reg_counter
    import hazard_pkg::*;
#(
    parameter int unsigned LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             wb_hit,
    input  logic             flush,
    output logic [LAT_W-1:0] cnt
);
    localparam logic [LAT_W-1:0] WAIT_WB = '1;

    // Priority: issue > writeback > flush > decrement; waiting entries survive flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= issue_lat;
        end else if (wb_hit && (cnt == WAIT_WB)) begin
            cnt <= '0;
        end else if (flush) begin
            if (cnt != WAIT_WB) cnt <= '0;
        end else if ((cnt != '0) && (cnt != WAIT_WB)) begin
            cnt <= cnt - LAT_W'(1);
        end
    end
endmodule

// File: rtl/multicycle_hazard_unit.sv
// Scoreboard-based RAW/WAW hazard detection beside ID, with stall counter.
module multicycle_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LAT_W    = LAT_W_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_hazard_unit_if.slave   hz
);
    localparam logic [LAT_W-1:0] WAIT_WB = '1;

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            busy;
    logic [NUM_SRC-1:0]             src_hz;
    reg_idx_t                       rs;
    logic                           waw;
    logic                           hazard;
    logic                           stall;
    logic                           issue_go;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic issue_r;
        logic wb_r;
        assign issue_r = issue_go && (hz.id_rd == REG_IDX_W'(r));
        assign wb_r    = hz.wb_valid && (hz.wb_rd == REG_IDX_W'(r));

        hazard_reg_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .issue     (issue_r),
            .issue_lat (hz.id_lat),
            .wb_hit    (wb_r),
            .flush     (hz.flush),
            .cnt       (cnt[r])
        );
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    // RAW check per source operand; x0 never busy.
    always_comb begin
        src_hz = '0;
        rs     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs        = hz.id_rs[i*REG_IDX_W +: REG_IDX_W];
            src_hz[i] = hz.id_valid && hz.id_rs_used[i] && (rs != '0) && busy[rs];
        end
    end

    assign waw      = hz.id_valid && hz.id_rd_we && (hz.id_rd != '0) && (cnt[hz.id_rd] == WAIT_WB);
    assign hazard   = (|src_hz) || waw;
    assign stall    = hazard && !hz.flush;
    assign issue_go = hz.id_valid && !hazard && !hz.flush && hz.id_rd_we && (hz.id_rd != '0);

    assign hz.stall_if_id = stall;
    assign hz.bubble_ex   = stall;
    assign hz.src_hazard  = src_hz;
    assign hz.busy_mask   = busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hz.stall_cycles <= '0;
        end else if (stall && (hz.stall_cycles != '1)) begin
            hz.stall_cycles <= hz.stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_hazard_unit.sv
// Directed and randomized check of multicycle_hazard_unit against a scoreboard model.
module tb_multicycle_hazard_unit;
    localparam int WAITV = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_hazard_unit_if #(.NUM_REGS(32), .NUM_SRC(2), .LAT_W(3), .CNT_W(32)) hz ();

    multicycle_hazard_unit #(.NUM_REGS(32), .NUM_SRC(2), .LAT_W(3), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_cnt[32];
    longint      m_stall = 0;
    bit          model_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input bit [1:0] used,
                         input int rd, input bit we, input int lat, input bit fl,
                         input bit wbv, input int wbr);
        hz.id_valid   = v;
        hz.id_rs      = {5'(rs2), 5'(rs1)};
        hz.id_rs_used = used;
        hz.id_rd      = 5'(rd);
        hz.id_rd_we   = we;
        hz.id_lat     = 3'(lat);
        hz.flush      = fl;
        hz.wb_valid   = wbv;
        hz.wb_rd      = 5'(wbr);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected hazard outputs from the scoreboard and current ID inputs.
    function automatic void model_out(output bit [1:0] src, output bit waw, output bit stall);
        int rs;
        for (int i = 0; i < 2; i++) begin
            rs = (i == 0) ? int'(hz.id_rs[4:0]) : int'(hz.id_rs[9:5]);
            src[i] = hz.id_valid && hz.id_rs_used[i] && (rs != 0) && (m_cnt[rs] != 0);
        end
        waw   = hz.id_valid && hz.id_rd_we && (hz.id_rd != 0) && (m_cnt[int'(hz.id_rd)] == WAITV);
        stall = ((|src) || waw) && !hz.flush;
    endfunction

    task automatic cycle();
        bit [1:0]    es;
        bit          ew;
        bit          est;
        logic [31:0] eb;
        int          nxt[32];
        bit          issue;
        model_out(es, ew, est);
        if (model_on) begin
            eb = '0;
            for (int r = 1; r < 32; r++) eb[r] = (m_cnt[r] != 0);
            chk("stall_if_id", 64'(hz.stall_if_id), 64'(est));
            chk("bubble_ex", 64'(hz.bubble_ex), 64'(est));
            chk("src_hazard", 64'(hz.src_hazard), 64'(es));
            chk("busy_mask", 64'(hz.busy_mask), 64'(eb));
            chk("stall_cycles", 64'(hz.stall_cycles), 64'(m_stall));
        end
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_stall  = 0;
            model_on = 1'b1;
        end else begin
            if (est && m_stall != 64'hFFFF_FFFF) m_stall++;
            issue = hz.id_valid && !((|es) || ew) && !hz.flush && hz.id_rd_we && (hz.id_rd != 0);
            nxt = m_cnt;
            for (int r = 1; r < 32; r++) begin
                if (nxt[r] > 0 && nxt[r] < WAITV) nxt[r] = nxt[r] - 1;
                if (hz.flush && m_cnt[r] != WAITV) nxt[r] = 0;
            end
            if (hz.wb_valid && hz.wb_rd != 0 && m_cnt[int'(hz.wb_rd)] == WAITV) nxt[int'(hz.wb_rd)] = 0;
            if (issue) nxt[int'(hz.id_rd)] = int'(hz.id_lat);
            m_cnt = nxt;
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (m_cnt[r]) m_cnt[r] = 0;
        rst_n = 1'b0;
        idle();
        cycle();
        rst_n = 1'b1;
        idle();
        chk("reset_busy", 64'(hz.busy_mask), 64'd0);
        chk("reset_stall_cycles", 64'(hz.stall_cycles), 64'd0);
        cycle();

        // Load-use: one bubble
        drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0);
        cycle();
        drive(1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0);
        chk("lu_stall", 64'(hz.stall_if_id), 64'd1);
        chk("lu_bubble", 64'(hz.bubble_ex), 64'd1);
        chk("lu_src", 64'(hz.src_hazard), 64'd1);
        cycle();
        chk("lu_release", 64'(hz.stall_if_id), 64'd0);
        cycle();
        idle();
        chk("lu_stall_cycles", 64'(hz.stall_cycles), 64'd1);
        cycle();

        // Latency 3 on rs2: three bubbles
        drive(1, 0, 0, 2'b00, 7, 1, 3, 0, 0, 0);
        cycle();
        drive(1, 2, 7, 2'b11, 8, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("l3_stall", 64'(hz.stall_if_id), 64'd1);
            chk("l3_src", 64'(hz.src_hazard), 64'd2);
            cycle();
        end
        chk("l3_release", 64'(hz.stall_if_id), 64'd0);
        chk("l3_busy7", 64'(hz.busy_mask[7]), 64'd0);
        cycle();
        idle();
        chk("l3_stall_cycles", 64'(hz.stall_cycles), 64'd4);
        cycle();

        // Variable latency on x9, WAW, then writeback
        drive(1, 0, 0, 2'b00, 9, 1, WAITV, 0, 0, 0);
        cycle();
        drive(1, 9, 0, 2'b01, 10, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            chk("div_stall", 64'(hz.stall_if_id), 64'd1);
            cycle();
        end
        drive(1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 0);
        chk("waw_stall", 64'(hz.stall_if_id), 64'd1);
        chk("waw_src", 64'(hz.src_hazard), 64'd0);
        cycle();
        drive(1, 9, 0, 2'b01, 10, 1, 0, 0, 1, 9);
        chk("wb_cycle_stall", 64'(hz.stall_if_id), 64'd1);
        cycle();
        drive(1, 9, 0, 2'b01, 10, 1, 0, 0, 0, 0);
        chk("wb_release", 64'(hz.stall_if_id), 64'd0);
        cycle();
        idle();
        chk("div_stall_cycles", 64'(hz.stall_cycles), 64'd11);
        cycle();

        // Flush during latency-2 stall while x9 waits on writeback
        drive(1, 0, 0, 2'b00, 9, 1, WAITV, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 2'b00, 4, 1, 2, 0, 0, 0);
        cycle();
        drive(1, 4, 0, 2'b01, 11, 1, 0, 0, 0, 0);
        chk("fl_pre_stall", 64'(hz.stall_if_id), 64'd1);
        cycle();
        drive(1, 4, 0, 2'b01, 11, 1, 0, 1, 0, 0);
        chk("fl_stall", 64'(hz.stall_if_id), 64'd0);
        chk("fl_bubble", 64'(hz.bubble_ex), 64'd0);
        cycle();
        idle();
        chk("fl_busy", 64'(hz.busy_mask), 64'h200);
        cycle();

        // x0 destination and unused sources never stall
        drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 2'b11, 12, 0, 0, 0, 0, 0);
        chk("x0_stall", 64'(hz.stall_if_id), 64'd0);
        cycle();
        drive(1, 0, 0, 2'b00, 5, 1, 3, 0, 0, 0);
        cycle();
        drive(1, 1, 5, 2'b01, 12, 0, 0, 0, 0, 0);
        chk("unused_stall", 64'(hz.stall_if_id), 64'd0);
        chk("unused_src", 64'(hz.src_hazard), 64'd0);
        cycle();

        // Issue to x3 alongside a writeback naming x3 (not waiting): issue wins
        drive(1, 0, 0, 2'b00, 3, 1, 2, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 2'b00, 3, 1, 3, 0, 1, 3);
        chk("x3_issue_stall", 64'(hz.stall_if_id), 64'd0);
        cycle();
        idle();
        chk("x3_busy", 64'(hz.busy_mask[3]), 64'd1);
        cycle();
        drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        chk("x3_stall_a", 64'(hz.stall_if_id), 64'd1);
        cycle();
        chk("x3_stall_b", 64'(hz.stall_if_id), 64'd1);
        cycle();
        chk("x3_release", 64'(hz.stall_if_id), 64'd0);
        cycle();

        // Reset asserted mid-stall
        drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        chk("rst_pre_stall", 64'(hz.stall_if_id), 64'd1);
        cycle();
        rst_n = 1'b0;
        drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        cycle();
        rst_n = 1'b1;
        drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        chk("rst_stall", 64'(hz.stall_if_id), 64'd0);
        chk("rst_busy", 64'(hz.busy_mask), 64'd0);
        chk("rst_stall_cycles", 64'(hz.stall_cycles), 64'd0);
        cycle();

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 4000; n++) begin
            int lat;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: lat = 0;
                1: lat = 1;
                2: lat = 2;
                3: lat = WAITV;
                default: lat = int'($urandom_range(0, 7));
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), lat,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
            cycle();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
